// File: rtl/shift_sequencer_pkg.sv
// Shared encodings, state type and default width for shift_sequencer.
// Optional rotate support is selected in the top via SHIFT_SEQUENCER_ROTATE_EN.
package shift_sequencer_pkg;

    localparam int unsigned SHAMT_W_DEF = 5;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_SLLV = 3'b011;
    localparam logic [2:0] OP_SRLV = 3'b100;
    localparam logic [2:0] OP_SRAV = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam logic [2:0] CTL_HOLD = 3'b000;
    localparam logic [2:0] CTL_LOAD = 3'b001;
    localparam logic [2:0] CTL_SLL1 = 3'b010;
    localparam logic [2:0] CTL_SRL1 = 3'b011;
    localparam logic [2:0] CTL_SRA1 = 3'b100;
    localparam logic [2:0] CTL_ROR1 = 3'b101;

    localparam logic [1:0] SRC_B    = 2'b00;
    localparam logic [1:0] SRC_A    = 2'b01;
    localparam logic [1:0] SRC_IMM  = 2'b10;
    localparam logic [1:0] SRC_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Single-bit shift code for an op; reserved ops map to hold.
    function automatic logic [2:0] shift_code(input logic [2:0] op);
        logic [2:0] code;
        code = CTL_HOLD;
        case (op)
            OP_SLL, OP_SLLV: code = CTL_SLL1;
            OP_SRL, OP_SRLV: code = CTL_SRL1;
            OP_SRA, OP_SRAV: code = CTL_SRA1;
            OP_ROR:          code = CTL_ROR1;
            default:         code = CTL_HOLD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: IDLE -> LOAD -> SHIFT x count -> DONE.
// Define SHIFT_SEQUENCER_ROTATE_EN to enable op 110 (rotate right).
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [1:0]         src_sel,
    input  logic [SHAMT_W-1:0] shamt_imm,
    input  logic [SHAMT_W-1:0] shamt_reg,
    output logic [1:0]         dis_reg_e,
    output logic [2:0]         shift_ctl,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [1:0]         src_q, src_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               op_rsvd;
    logic [2:0]         op_code;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
    assign op_rsvd = (op == OP_RSVD);
    assign op_code = shift_code(op_q);
`else
    assign op_rsvd = (op == OP_RSVD) || (op == OP_ROR);
    assign op_code = (op_q == OP_ROR) ? CTL_HOLD : shift_code(op_q);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            src_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_d     = src_q;
        count_d   = count_q;
        dis_reg_e = '0;
        shift_ctl = CTL_HOLD;
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    src_d   = src_sel;
                    state_d = ST_LOAD;
                    if (op_rsvd)
                        count_d = '0;
                    else if (op inside {OP_SLLV, OP_SRLV, OP_SRAV})
                        count_d = shamt_reg;
                    else
                        count_d = shamt_imm;
                end
            end
            ST_LOAD: begin
                shift_ctl = CTL_LOAD;
                dis_reg_e = src_q;
                state_d   = (count_q != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                shift_ctl = op_code;
                dis_reg_e = src_q;
                // Saturating decrement; leaves on the final shift cycle.
                if (count_q != '0)
                    count_d = count_q - SHAMT_W'(1);
                if (count_q <= SHAMT_W'(1))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                dis_reg_e = src_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: per-cycle expected outputs queued at issue.
// Honours SHIFT_SEQUENCER_ROTATE_EN the same way as the design build.
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [1:0]   src_sel;
    logic [W-1:0] shamt_imm;
    logic [W-1:0] shamt_reg;
    logic [1:0]   dis_reg_e;
    logic [2:0]   shift_ctl;
    logic         busy;
    logic         done;

    shift_sequencer #(.SHAMT_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src_sel   (src_sel),
        .shamt_imm (shamt_imm),
        .shamt_reg (shamt_reg),
        .dis_reg_e (dis_reg_e),
        .shift_ctl (shift_ctl),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  ctl;
        logic [1:0]  dis;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned dones = 0;
    int unsigned cyc = 0;
    int unsigned free_iv = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle the DUT outputs must match the queued expectation or be idle.
    always @(negedge clk) begin
        exp_t e;
        if (cyc >= 1) begin
            if (done) dones++;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_cycle expected activity at cycle %0d not seen (now %0d)", q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc)
                e = q.pop_front();
            else
                e = '{cyc: cyc, ctl: 3'b000, dis: 2'b00, busy: 1'b0, done: 1'b0};
            total++;
            if (shift_ctl !== e.ctl || dis_reg_e !== e.dis || busy !== e.busy || done !== e.done) begin
                bad++;
                $display("FAIL cycle_%0d got ctl=%b dis=%b busy=%b done=%b want ctl=%b dis=%b busy=%b done=%b",
                         cyc, shift_ctl, dis_reg_e, busy, done, e.ctl, e.dis, e.busy, e.done);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned model_n(input logic [2:0] o, input logic [W-1:0] im, input logic [W-1:0] rg);
        int unsigned n;
        case (o)
            3'b011, 3'b100, 3'b101: n = rg;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
            3'b110: n = im;
`else
            3'b110: n = 0;
`endif
            3'b111: n = 0;
            default: n = im;
        endcase
        return n;
    endfunction

    // Shift family is op mod 3 (left, logical right, arithmetic right); rotate is separate.
    function automatic logic [2:0] model_code(input logic [2:0] o);
        int unsigned oi;
        oi = o;
        if (o == 3'b110) return 3'b101;
        return 3'(2 + oi % 3);
    endfunction

    task automatic issue(input logic [2:0] o, input logic [1:0] s, input logic [W-1:0] im,
                         input logic [W-1:0] rg, output int unsigned t);
        int unsigned n;
        exp_t e;
        while (cyc < free_iv) step();
        op = o; src_sel = s; shamt_imm = im; shamt_reg = rg; start = 1'b1;
        t = cyc;
        n = model_n(o, im, rg);
        e = '{cyc: t + 1, ctl: 3'b001, dis: s, busy: 1'b1, done: 1'b0};
        q.push_back(e);
        for (int unsigned k = 0; k < n; k++) begin
            e = '{cyc: t + 2 + k, ctl: model_code(o), dis: s, busy: 1'b1, done: 1'b0};
            q.push_back(e);
        end
        e = '{cyc: t + 2 + n, ctl: 3'b000, dis: s, busy: 1'b1, done: 1'b1};
        q.push_back(e);
        free_iv = t + 3 + n;
        step();
        start = 1'b0;
        op = 3'($urandom); src_sel = 2'($urandom);
        shamt_imm = W'($urandom); shamt_reg = W'($urandom);
    endtask

    task automatic pulse_reset(input logic with_start);
        reset = 1'b0;
        start = with_start;
        while (q.size() > 0 && q[$].cyc >= cyc + 1) void'(q.pop_back());
        step();
        reset = 1'b1;
        start = 1'b0;
        free_iv = cyc;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() > 0; i++) step();
        step();
    endtask

    initial begin
        int unsigned t;
        int unsigned d0;
        reset = 1'b0; start = 1'b0; op = '0; src_sel = '0; shamt_imm = '0; shamt_reg = '0;
        repeat (3) step();
        reset = 1'b1;
        free_iv = cyc;

        issue(3'b000, 2'b00, W'(3), W'(9), t);    // SLL imm=3
        issue(3'b101, 2'b01, W'(7), W'(0), t);    // SRAV reg=0 -> no shift
        issue(3'b001, 2'b10, W'(31), W'(4), t);   // SRL N=31

        // Abort on the second SHIFT cycle of an N=5 op, then a normal op.
        issue(3'b000, 2'b11, W'(5), W'(0), t);
        while (cyc < t + 3) step();
        pulse_reset(1'b0);
        issue(3'b010, 2'b01, W'(4), W'(0), t);

        // Starts during SHIFT and during DONE are dropped.
        drain();
        d0 = dones;
        issue(3'b100, 2'b10, W'(9), W'(5), t);
        while (cyc < t + 3) step();
        start = 1'b1; op = 3'b000; shamt_imm = W'(2);
        step();
        start = 1'b0;
        while (cyc < t + 7) step();
        start = 1'b1; op = 3'b001; shamt_imm = W'(1);
        step();
        start = 1'b0;
        drain();
        total++;
        if (dones - d0 != 1) begin
            bad++;
            $display("FAIL done_count got %0d want 1", dones - d0);
        end

        // Reset wins over a simultaneous start.
        while (cyc < free_iv) step();
        op = 3'b000; shamt_imm = W'(3);
        pulse_reset(1'b1);
        repeat (3) step();

        issue(3'b110, 2'b00, W'(2), W'(0), t);    // ROR N=2

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) step();
            issue(3'($urandom), 2'($urandom), W'($urandom), W'($urandom), t);
            while (cyc < free_iv) begin
                start = ($urandom_range(0, 3) == 0);
                op = 3'($urandom); src_sel = 2'($urandom);
                shamt_imm = W'($urandom); shamt_reg = W'($urandom);
                step();
            end
            start = 1'b0;
        end

        drain();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending expectations want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
